// File: rtl/clock_div_pkg.sv
// Shared types, defaults and helpers for the programmable clock divider.
package clock_div_pkg;

  localparam int WIDTH_DEFAULT       = 18;
  localparam int DEFAULT_DIV_DEFAULT = 131072;

  typedef logic [WIDTH_DEFAULT-1:0] div_t;

  // ceil(n/2) with one spare bit so n = all-ones cannot overflow.
  function automatic logic [32:0] half_ceil(input logic [31:0] n);
    return ({1'b0, n} + 33'd1) >> 1;
  endfunction

endpackage

// File: rtl/clock_div_phase_ctr.sv
// Phase counter for the clock divider: wrap detection, enable hold and restart.
module clock_div_phase_ctr
  import clock_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] phase,
  output logic [WIDTH-1:0] next_phase,
  output logic             wrap
);

  logic [WIDTH-1:0] last;
  logic             short_n;

  always_comb begin
    short_n = (n <= WIDTH'(1));
    // n = 0 would underflow; halted divider never wraps anyway.
    last    = (n == '0) ? '0 : n - WIDTH'(1);
    wrap    = enable && !restart && (n != '0) && (phase == last);

    next_phase = phase;
    if (restart) begin
      next_phase = '0;
    end else if (enable) begin
      if (short_n || (phase == last)) begin
        next_phase = '0;
      end else begin
        next_phase = phase + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase <= '0;
    end else begin
      phase <= next_phase;
    end
  end

endmodule

// File: rtl/clock_div_prog.sv
// Runtime-programmable clock divider: divided square wave plus one-cycle tick,
// with divisor changes deferred to the period boundary.
module clock_div_prog
  import clock_div_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] div_value,
  input  logic             restart,
  output logic             div_clock,
  output logic             tick,
  output logic             load_pending,
  output logic [WIDTH-1:0] phase
);

  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] next_n;
  logic [WIDTH-1:0] pend_next;
  logic [WIDTH-1:0] pend_value;
  logic [WIDTH-1:0] next_phase;
  logic             wrap;
  logic             have_pending;
  logic             apply;
  logic             swap;
  logic             pending_next;
  logic             div_clock_next;
  logic             tick_next;
  logic [32:0]      lo;

  clock_div_phase_ctr #(
    .WIDTH(WIDTH)
  ) u_phase_ctr (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .restart    (restart),
    .n          (n_q),
    .phase      (phase),
    .next_phase (next_phase),
    .wrap       (wrap)
  );

  always_comb begin
    // A load in the same cycle as the apply edge bypasses the pending register.
    have_pending = load | load_pending;
    pend_value   = load ? div_value : pend_q;
    apply        = restart | wrap | (n_q <= WIDTH'(1));
    swap         = apply & have_pending;
    next_n       = swap ? pend_value : n_q;
    pending_next = have_pending & ~apply;
    pend_next    = load ? div_value : pend_q;
    lo           = half_ceil(32'(next_n));

    div_clock_next = div_clock;
    tick_next      = 1'b0;
    if (restart) begin
      div_clock_next = 1'b0;
    end else if (enable || swap) begin
      if (next_n == '0) begin
        div_clock_next = 1'b0;
      end else if (next_n == WIDTH'(1)) begin
        div_clock_next = 1'b1;
      end else begin
        div_clock_next = (33'(next_phase) >= lo);
      end
      tick_next = enable && (next_n != '0) && (next_phase == next_n - WIDTH'(1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      n_q          <= WIDTH'(DEFAULT_DIV);
      pend_q       <= '0;
      load_pending <= 1'b0;
      div_clock    <= 1'b0;
      tick         <= 1'b0;
    end else begin
      n_q          <= next_n;
      pend_q       <= pend_next;
      load_pending <= pending_next;
      div_clock    <= div_clock_next;
      tick         <= tick_next;
    end
  end

endmodule

// File: tb/tb_clock_div_prog.sv
// Bench for clock_div_prog with WIDTH=8, DEFAULT_DIV=4: table of hand-derived
// vectors plus a few sweeps, expectations queued at drive time.
module tb_clock_div_prog;

  localparam int W = 8;

  typedef struct {
    logic         rst;
    logic         en;
    logic         ld;
    logic [W-1:0] dv;
    logic         rs;
    logic [W-1:0] ph;
    logic         dc;
    logic         tk;
    logic         lp;
  } vec_t;

  typedef struct {
    logic [W-1:0] ph;
    logic         dc;
    logic         tk;
    logic         lp;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] div_value = '0;
  logic         restart = 1'b0;
  logic         div_clock;
  logic         tick;
  logic         load_pending;
  logic [W-1:0] phase;

  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  vec_t tbl[$];
  exp_t exp_q[$];

  clock_div_prog #(
    .WIDTH       (W),
    .DEFAULT_DIV (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .load         (load),
    .div_value    (div_value),
    .restart      (restart),
    .div_clock    (div_clock),
    .tick         (tick),
    .load_pending (load_pending),
    .phase        (phase)
  );

  always #5 clock = ~clock;

  task automatic add(input int rst, input int en, input int ld, input int dv, input int rs,
                     input int ph, input int dc, input int tk, input int lp);
    vec_t v;
    v.rst = rst[0]; v.en = en[0]; v.ld = ld[0]; v.dv = dv[W-1:0]; v.rs = rs[0];
    v.ph = ph[W-1:0]; v.dc = dc[0]; v.tk = tk[0]; v.lp = lp[0];
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, step_no, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    exp_t got;
    reset     = v.rst;
    enable    = v.en;
    load      = v.ld;
    div_value = v.dv;
    restart   = v.rs;
    e.ph = v.ph; e.dc = v.dc; e.tk = v.tk; e.lp = v.lp;
    exp_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
    step_no++;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard step %0d: got empty queue, expected an entry", step_no);
    end else begin
      got = exp_q.pop_front();
      chk("phase", 32'(phase), 32'(got.ph));
      chk("div_clock", 32'(div_clock), 32'(got.dc));
      chk("tick", 32'(tick), 32'(got.tk));
      chk("load_pending", 32'(load_pending), 32'(got.lp));
    end
  endtask

  task automatic run(input int en, input int ld, input int dv, input int rs,
                     input int ph, input int dc, input int tk, input int lp);
    vec_t v;
    v.rst = 1'b0; v.en = en[0]; v.ld = ld[0]; v.dv = dv[W-1:0]; v.rs = rs[0];
    v.ph = ph[W-1:0]; v.dc = dc[0]; v.tk = tk[0]; v.lp = lp[0];
    step(v);
  endtask

  initial begin
    // rst en ld dv rs | ph dc tk lp
    add(1, 1, 0, 0, 0,  0, 0, 0, 0);
    add(1, 0, 0, 0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  2, 1, 0, 0);
    add(0, 1, 0, 0, 0,  3, 1, 1, 0);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 0, 0, 0);
    // load 5 at phase 1
    add(0, 1, 1, 5, 0,  2, 1, 0, 1);
    add(0, 1, 0, 0, 0,  3, 1, 1, 1);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  2, 0, 0, 0);
    add(0, 1, 0, 0, 0,  3, 1, 0, 0);
    add(0, 1, 0, 0, 0,  4, 1, 1, 0);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0);
    // loads 6 then 3, only 3 applied
    add(0, 1, 1, 6, 0,  1, 0, 0, 1);
    add(0, 1, 1, 3, 0,  2, 0, 0, 1);
    add(0, 1, 0, 0, 0,  3, 1, 0, 1);
    add(0, 1, 0, 0, 0,  4, 1, 1, 1);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  2, 1, 1, 0);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  2, 1, 1, 0);
    // load on the wrap edge takes effect immediately
    add(0, 1, 1, 4, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  2, 1, 0, 0);
    add(0, 1, 0, 0, 0,  3, 1, 1, 0);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  2, 1, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0,  2, 1, 0, 0);
    add(0, 1, 0, 0, 0,  3, 1, 1, 0);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0);
    // load while disabled, then restart applies it
    add(0, 0, 1, 6, 0,  0, 0, 0, 1);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  2, 0, 0, 0);
    add(0, 1, 0, 0, 0,  3, 1, 0, 0);
    add(0, 1, 0, 0, 0,  4, 1, 0, 0);
    add(0, 1, 0, 0, 0,  5, 1, 1, 0);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0);
    // N = 0 halted
    add(0, 1, 1, 0, 1,  0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0,  0, 0, 0, 0);
    // N = 1
    add(0, 1, 1, 1, 1,  0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0,  0, 1, 1, 0);
    add(0, 0, 0, 0, 0,  0, 1, 0, 0);
    add(0, 1, 0, 0, 0,  0, 1, 1, 0);
    // back to 4, pend 7, reset at phase 2 discards it
    add(0, 1, 1, 4, 1,  0, 0, 0, 0);
    add(0, 1, 1, 7, 0,  1, 0, 0, 1);
    add(0, 1, 0, 0, 0,  2, 1, 0, 1);
    add(1, 1, 0, 0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  2, 1, 0, 0);
    add(0, 1, 0, 0, 0,  3, 1, 1, 0);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  2, 1, 0, 0);
    // restart mid-period
    add(0, 1, 0, 0, 1,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 0, 0, 0);

    @(negedge clock);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // largest divisor: LO = 128 must not overflow
    run(1, 1, 255, 1,  0, 0, 0, 0);
    for (int i = 1; i < 255; i++) run(1, 0, 0, 0,  i, (i >= 128) ? 1 : 0, (i == 254) ? 1 : 0, 0);
    run(1, 0, 0, 0,  0, 0, 0, 0);

    // N = 2: one low, one high
    run(1, 1, 2, 1,  0, 0, 0, 0);
    run(1, 0, 0, 0,  1, 1, 1, 0);
    run(1, 0, 0, 0,  0, 0, 0, 0);
    run(1, 0, 0, 0,  1, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
